// File: rtl/jtgng_objscan.sv
// Per-line sprite list builder: scans object RAM for line N+1 into a ping-pong buffer; JTGNG_OBJSCAN_REVERSE_EN fills slots top-down.
// Latency: one search cen per entry, OBJ_BYTES cens per copied hit; front-buffer read data one cen after {objcnt,pxlcnt}.
// Backpressure: none; all state advances on cen, and HINIT unconditionally restarts the scan.
module jtgng_objscan #(
  parameter int         AW          = 9,
  parameter int         OBJ_BYTES   = 4,
  parameter int         YBYTE       = 2,
  parameter int         OBJMAX      = 'h180,
  parameter int         OBJMAX_LINE = 24,
  parameter int         SPRH        = 16,
  parameter int         VOFS        = 3,
  parameter logic [7:0] FILL        = 8'hf8,
  localparam int        BW          = $clog2(OBJ_BYTES),
  localparam int        OCW         = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic           HINIT,
  input  logic           LVBL,
  input  logic [7:0]     V,
  input  logic           flip,
  output logic [7:0]     VF,
  output logic [AW-1:0]  scan_addr,
  input  logic [7:0]     ram_dout,
  input  logic [OCW-1:0] objcnt,
  input  logic [BW-1:0]  pxlcnt,
  output logic [7:0]     objbuf_data,
  output logic           line,
  output logic           ovf
);

  localparam int DEPTH   = 1 << (OCW + BW);
  localparam int SKIP_I  = YBYTE + 1;
  localparam int LASTB_I = OBJ_BYTES - 1;
  localparam int TOP_I   = OBJMAX_LINE - 1;

  localparam logic [AW:0]     Y_OFS    = YBYTE[AW:0];
  localparam logic [AW:0]     ENT_STEP = OBJ_BYTES[AW:0];
  localparam logic [AW:0]     LAST_Y   = OBJMAX[AW:0];
  localparam logic [AW:0]     SKIP     = SKIP_I[AW:0];
  localparam logic [OCW:0]    MAXL     = OBJMAX_LINE[OCW:0];
  localparam logic [OCW-1:0]  TOP      = TOP_I[OCW-1:0];
  localparam logic [BW-1:0]   LASTB    = LASTB_I[BW-1:0];
  localparam logic [7:0]      VOFS8    = VOFS[7:0];
  localparam logic [7:0]      SPRH8    = SPRH[7:0];

  typedef enum logic [1:0] {IDLE, SEARCH, TRANSFER, DONE} state_t;

  state_t          state, state_nx;
  logic [AW:0]     addr, addr_nx;
  logic [OCW:0]    cnt, cnt_nx;
  logic [BW-1:0]   byte_cnt, byte_nx;
  logic            ovf_pending, ovfp_nx;
  logic            last_ent, last_nx;
  logic            we;
  logic            hit;
  logic [7:0]      ydiff;
  logic [OCW-1:0]  wslot;
  logic [OCW+BW-1:0] waddr, raddr;

  logic [7:0] buf_a [0:DEPTH-1];
  logic [7:0] buf_b [0:DEPTH-1];

  assign scan_addr = addr[AW-1:0];

  // Modular distance so sprites straddling line 255/0 still match
  assign ydiff = VF + VOFS8 - ram_dout;
  assign hit   = ydiff < SPRH8;

`ifdef JTGNG_OBJSCAN_REVERSE_EN
  assign wslot = TOP - cnt[OCW-1:0];
`else
  assign wslot = cnt[OCW-1:0];
`endif

  assign waddr = {wslot, byte_cnt};
  assign raddr = {objcnt, pxlcnt};

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    cnt_nx   = cnt;
    byte_nx  = byte_cnt;
    ovfp_nx  = ovf_pending;
    last_nx  = last_ent;
    we       = 1'b0;
    if (HINIT) begin
      state_nx = LVBL ? SEARCH : IDLE;
      addr_nx  = Y_OFS;
      cnt_nx   = '0;
      byte_nx  = '0;
      ovfp_nx  = 1'b0;
      last_nx  = 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (hit) begin
            if (cnt == MAXL) begin
              ovfp_nx  = 1'b1;
              state_nx = DONE;
            end else begin
              state_nx = TRANSFER;
              byte_nx  = '0;
              addr_nx  = addr - Y_OFS;
              last_nx  = addr >= LAST_Y;
            end
          end else if (addr >= LAST_Y) begin
            state_nx = DONE;
          end else begin
            addr_nx = addr + ENT_STEP;
          end
        end
        TRANSFER: begin
          we      = 1'b1;
          byte_nx = byte_cnt + 1'b1;
          addr_nx = addr + 1'b1;
          if (byte_cnt == LASTB) begin
            // addr sits on the entry's last byte; step to the next entry's Y byte
            cnt_nx   = cnt + 1'b1;
            addr_nx  = addr + SKIP;
            state_nx = last_ent ? DONE : SEARCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= Y_OFS;
      cnt         <= '0;
      byte_cnt    <= '0;
      ovf_pending <= 1'b0;
      last_ent    <= 1'b0;
      ovf         <= 1'b0;
      line        <= 1'b0;
      VF          <= 8'd0;
    end else if (cen) begin
      state       <= state_nx;
      addr        <= addr_nx;
      cnt         <= cnt_nx;
      byte_cnt    <= byte_nx;
      ovf_pending <= ovfp_nx;
      last_ent    <= last_nx;
      if (HINIT) begin
        line <= ~line;
        VF   <= {8{flip}} ^ V;
        ovf  <= ovf_pending;
      end
    end
  end

  // line=0: A is the back (write) buffer, B the front (read-then-clear) buffer
  always_ff @(posedge clk) begin
    if (cen) begin
      if (!line) begin
        if (we) buf_a[waddr] <= ram_dout;
      end else begin
        buf_a[raddr] <= FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cen) begin
      if (line) begin
        if (we) buf_b[waddr] <= ram_dout;
      end else begin
        buf_b[raddr] <= FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      objbuf_data <= FILL;
    end else if (cen) begin
      objbuf_data <= line ? buf_a[raddr] : buf_b[raddr];
    end
  end

endmodule

// File: tb/tb_jtgng_objscan.sv
// Bench for jtgng_objscan: random object RAM images checked against a list-level model of each line's scan.
// Build with JTGNG_OBJSCAN_REVERSE_EN defined to exercise the top-down slot order.
module tb_jtgng_objscan;

  localparam int         AW          = 9;
  localparam int         OBJ_BYTES   = 4;
  localparam int         YBYTE       = 2;
  localparam int         OBJMAX      = 'h180;
  localparam int         OBJMAX_LINE = 24;
  localparam int         SPRH        = 16;
  localparam int         VOFS        = 3;
  localparam logic [7:0] FILL        = 8'hf8;
  localparam int         NBUF        = 128;
  localparam int         LINE_CENS   = 220;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cen = 1'b0;
  logic           HINIT = 1'b0;
  logic           LVBL = 1'b0;
  logic [7:0]     V = 8'd0;
  logic           flip = 1'b0;
  logic [7:0]     VF;
  logic [AW-1:0]  scan_addr;
  logic [7:0]     ram_dout;
  logic [4:0]     objcnt = 5'd0;
  logic [1:0]     pxlcnt = 2'd0;
  logic [7:0]     objbuf_data;
  logic           line;
  logic           ovf;

  logic [7:0] mem [0:511];
  logic [7:0] pend_dat [NBUF];
  bit         pend_chk [NBUF];
  bit         pend_ovf;
  bit         exp_line;
  int         n_cmp = 0;
  int         n_bad = 0;

  jtgng_objscan dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cen         (cen),
    .HINIT       (HINIT),
    .LVBL        (LVBL),
    .V           (V),
    .flip        (flip),
    .VF          (VF),
    .scan_addr   (scan_addr),
    .ram_dout    (ram_dout),
    .objcnt      (objcnt),
    .pxlcnt      (pxlcnt),
    .objbuf_data (objbuf_data),
    .line        (line),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= mem[scan_addr];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk) cen = 1'b1;
    @(negedge clk) cen = 1'b0;
  endtask

  function automatic int slot_of(input int k);
`ifdef JTGNG_OBJSCAN_REVERSE_EN
    return OBJMAX_LINE - 1 - k;
`else
    return k;
`endif
  endfunction

  // Sprite list the scan of one line must leave behind, straight from the matching rules
  task automatic model_scan(input logic [7:0] vf, input bit lv);
    int n;
    int a;
    logic [7:0] d;
    for (int i = 0; i < NBUF; i++) begin
      pend_dat[i] = FILL;
      pend_chk[i] = 1'b1;
    end
    pend_ovf = 1'b0;
    n = 0;
    if (lv) begin
      a = YBYTE;
      while (1) begin
        d = vf + 8'(VOFS) - mem[a];
        if (int'(d) < SPRH) begin
          if (n == OBJMAX_LINE) begin
            pend_ovf = 1'b1;
            break;
          end
          for (int b = 0; b < OBJ_BYTES; b++)
            pend_dat[slot_of(n) * OBJ_BYTES + b] = mem[a - YBYTE + b];
          n++;
        end
        if (a >= OBJMAX) break;
        a += OBJ_BYTES;
      end
    end
  endtask

  task automatic fill_miss(input logic [7:0] vf);
    for (int a = 0; a < 512; a++) mem[a] = 8'($urandom);
    for (int a = YBYTE; a < 512; a += OBJ_BYTES)
      mem[a] = vf + 8'(VOFS) + 8'(SPRH) + 8'($urandom_range(0, 224));
  endtask

  task automatic set_hit(input int k, input logic [7:0] vf);
    mem[YBYTE + k * OBJ_BYTES] = vf + 8'(VOFS) - 8'($urandom_range(0, SPRH - 1));
  endtask

  // One video line: HINIT, then read out (and clear) the front buffer while the scan runs
  task automatic run_line(input int ncen, input bit lv, input logic [7:0] v, input bit fl, input bit chkdat);
    logic [7:0] exp_dat [NBUF];
    bit         exp_chk [NBUF];
    bit         exp_ovf;
    logic [7:0] vf;
    exp_dat = pend_dat;
    exp_chk = pend_chk;
    exp_ovf = pend_ovf;
    vf = v ^ {8{fl}};
    model_scan(vf, lv);
    V = v;
    flip = fl;
    LVBL = lv;
    HINIT = 1'b1;
    tick;
    HINIT = 1'b0;
    exp_line = ~exp_line;
    check_val("line", 32'(line), 32'(exp_line));
    check_val("VF", 32'(VF), 32'(vf));
    check_val("scan_addr_start", 32'(scan_addr), 32'(YBYTE));
    check_val("ovf", 32'(ovf), 32'(exp_ovf));
    for (int c = 0; c < ncen; c++) begin
      if (c < NBUF) {objcnt, pxlcnt} = 7'(c);
      tick;
      if (chkdat && c < NBUF && exp_chk[c])
        check_val($sformatf("buf[%0d]", c), 32'(objbuf_data), 32'(exp_dat[c]));
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vf;
    bit         fl;
    int         p;
    int         last_k;
    int         last_y;

    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < NBUF; i++) begin
      pend_dat[i] = FILL;
      pend_chk[i] = 1'b0;
    end
    pend_ovf = 1'b0;
    exp_line = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    check_val("rst_line", 32'(line), 32'd0);
    check_val("rst_VF", 32'(VF), 32'd0);
    check_val("rst_scan_addr", 32'(scan_addr), 32'(YBYTE));
    check_val("rst_ovf", 32'(ovf), 32'd0);

    // Two idle lines so both buffers have been read out (cleared) once
    run_line(LINE_CENS, 1'b0, 8'd0, 1'b0, 1'b0);
    run_line(LINE_CENS, 1'b0, 8'd0, 1'b0, 1'b0);

    // VF=100 (via flip) against Y = 97, 112, 84, 85
    fill_miss(8'd100);
    mem[YBYTE + 0]  = 8'd97;
    mem[YBYTE + 4]  = 8'd112;
    mem[YBYTE + 8]  = 8'd84;
    mem[YBYTE + 12] = 8'd85;
    run_line(LINE_CENS, 1'b1, ~8'd100, 1'b1, 1'b1);

    // Wrap-around hit, then a far miss
    fill_miss(8'd2);
    mem[YBYTE] = 8'd250;
    run_line(LINE_CENS, 1'b1, 8'd2, 1'b0, 1'b1);
    fill_miss(8'd200);
    mem[YBYTE] = 8'd10;
    run_line(LINE_CENS, 1'b1, 8'd200, 1'b0, 1'b1);

    // Hit on the very last scanned entry is copied in full
    last_y = YBYTE;
    while (last_y < OBJMAX) last_y += OBJ_BYTES;
    last_k = (last_y - YBYTE) / OBJ_BYTES;
    vf = 8'($urandom);
    fill_miss(vf);
    set_hit(1, vf);
    set_hit(last_k, vf);
    run_line(LINE_CENS, 1'b1, vf, 1'b0, 1'b1);

    // 30 hits: 24 stored, overflow flagged next line, cleared after an empty line
    fill_miss(8'd60);
    for (int k = 0; k < 30; k++) mem[YBYTE + k * OBJ_BYTES] = 8'd60;
    run_line(LINE_CENS, 1'b1, 8'd60, 1'b0, 1'b1);
    fill_miss(8'd61);
    run_line(LINE_CENS, 1'b1, 8'd61, 1'b0, 1'b1);
    fill_miss(8'd62);
    run_line(LINE_CENS, 1'b1, 8'd62, 1'b0, 1'b1);

    for (int r = 0; r < 10; r++) begin
      vf = 8'($urandom);
      fl = 1'($urandom);
      p = $urandom_range(0, 3) * 12;
      fill_miss(vf);
      for (int k = 0; k <= last_k; k++)
        if ($urandom_range(0, 99) < p) set_hit(k, vf);
      run_line(LINE_CENS, ($urandom_range(0, 5) != 0), vf ^ {8{fl}}, fl, 1'b1);
    end

    // HINIT while sprite 5 is being copied (each hit takes one search plus four byte cens)
    fill_miss(8'd40);
    run_line(LINE_CENS, 1'b0, 8'd40, 1'b0, 1'b1);
    fill_miss(8'd120);
    for (int k = 0; k < 10; k++) set_hit(k, 8'd120);
    run_line(28, 1'b1, 8'd120, 1'b0, 1'b1);
    for (int b = 0; b < OBJ_BYTES; b++) pend_chk[slot_of(5) * OBJ_BYTES + b] = 1'b0;
    for (int s = 6; s < 10; s++)
      for (int b = 0; b < OBJ_BYTES; b++) pend_dat[slot_of(s) * OBJ_BYTES + b] = FILL;
    run_line(LINE_CENS, 1'b1, 8'd120, 1'b0, 1'b1);
    fill_miss(8'd33);
    run_line(LINE_CENS, 1'b0, 8'd33, 1'b0, 1'b1);

    // Reset in the middle of a copy while line=1 and ovf=1
    if (exp_line == 1'b0) begin
      fill_miss(8'd0);
      run_line(LINE_CENS, 1'b0, 8'd0, 1'b0, 1'b1);
    end
    fill_miss(8'd70);
    for (int k = 0; k < 30; k++) set_hit(k, 8'd70);
    run_line(LINE_CENS, 1'b1, 8'd70, 1'b0, 1'b1);
    fill_miss(8'd90);
    for (int k = 0; k < 4; k++) set_hit(k, 8'd90);
    run_line(3, 1'b1, 8'd90, 1'b0, 1'b1);
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    check_val("rst2_line", 32'(line), 32'd0);
    check_val("rst2_ovf", 32'(ovf), 32'd0);
    check_val("rst2_scan_addr", 32'(scan_addr), 32'(YBYTE));
    check_val("rst2_VF", 32'(VF), 32'd0);
    repeat (4) tick;
    check_val("rst2_idle_addr", 32'(scan_addr), 32'(YBYTE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
